tree_sched: RTL

Round-robin scheduler that shares one pipelined `tree` reduction unit (16-bit `a` in, 1-bit `b` out, fixed latency) among several requesters. It accepts at most one operand per cycle and drives it into the tree. A tag pipeline follows each operand through the tree, so every result is returned to the requester that issued it. Per-requester outstanding limits bound the number of in-flight operations. The block sits between the requester ports and a `tree` instance that is instantiated beside it.

---
 rtl/tree_sched.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/tree_sched.sv
// tree_sched: round-robin front end that shares one pipelined tree reduction
// unit among NUM_REQ requesters. A tag pipeline runs alongside the tree so
// that each result is routed back to the requester that issued the operand.
// A per-requester in-flight counter bounds how many operations each
// requester can have outstanding at once.
module tree_sched #(
  parameter int NUM_REQ  = 4,
  parameter int TREE_LAT = 2,
  parameter int MAX_OUT  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [16*NUM_REQ-1:0]  req_a,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     resp_valid,
  output logic                   resp_b,
  output logic [15:0]            tree_a,
  input  logic                   tree_b,
  output logic                   busy
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(MAX_OUT + 1);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_REQ - 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(MAX_OUT);

  logic [IDW-1:0]                rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0][CW-1:0]    cnt_q, cnt_d;
  logic [TREE_LAT:0]             tag_vld_q, tag_vld_d;
  logic [TREE_LAT:0][IDW-1:0]    tag_id_q, tag_id_d;
  logic [15:0]                   tree_a_q, tree_a_d;
  logic [NUM_REQ-1:0]            resp_valid_q, resp_valid_d;
  logic                          resp_b_q, resp_b_d;

  logic [NUM_REQ-1:0]            elig;
  logic                          hi_vld, lo_vld;
  logic [IDW-1:0]                hi_id, lo_id;
  logic                          grant_vld;
  logic [IDW-1:0]                grant_id;
  logic [15:0]                   grant_a;
  logic [NUM_REQ-1:0]            inc_vec, dec_vec;
  logic                          ret_vld;
  logic [IDW-1:0]                ret_id;

  assign ret_vld = tag_vld_q[TREE_LAT];
  assign ret_id  = tag_id_q[TREE_LAT];

  // Eligibility uses the pre-edge count, so a retire this cycle does not
  // free a slot until the following cycle.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = req_valid[i] && (cnt_q[i] < CNT_MAX);
    end
  end

  // Round-robin pick: first eligible at or above rr_ptr, else lowest eligible (wrap).
  always_comb begin
    hi_vld = 1'b0;
    hi_id  = '0;
    lo_vld = 1'b0;
    lo_id  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (elig[i] && !lo_vld) begin
        lo_vld = 1'b1;
        lo_id  = IDW'(i);
      end
      if (elig[i] && !hi_vld && (IDW'(i) >= rr_ptr_q)) begin
        hi_vld = 1'b1;
        hi_id  = IDW'(i);
      end
    end
    grant_vld = (hi_vld | lo_vld) & ~rst;
    grant_id  = hi_vld ? hi_id : lo_id;
  end

  // Decode grant and retire into per-requester strobes and select the operand.
  always_comb begin
    grant_a = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      inc_vec[i]   = grant_vld && (grant_id == IDW'(i));
      dec_vec[i]   = ret_vld && (ret_id == IDW'(i));
      req_ready[i] = inc_vec[i];
      if (inc_vec[i]) begin
        grant_a = req_a[16*i +: 16];
      end
    end
  end

  // Next state: issue into the tree, shift tags, retire, track in-flight counts.
  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    tree_a_d     = 16'h0000;
    tag_vld_d    = '0;
    tag_id_d     = '0;
    resp_valid_d = '0;
    resp_b_d     = 1'b0;
    cnt_d        = cnt_q;

    tag_vld_d[0] = grant_vld;
    tag_id_d[0]  = grant_vld ? grant_id : '0;
    for (int k = 1; k <= TREE_LAT; k++) begin
      tag_vld_d[k] = tag_vld_q[k-1];
      tag_id_d[k]  = tag_id_q[k-1];
    end

    if (grant_vld) begin
      tree_a_d = grant_a;
      rr_ptr_d = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
    end

    if (ret_vld) begin
      resp_valid_d = dec_vec;
      resp_b_d     = tree_b;
    end

    for (int i = 0; i < NUM_REQ; i++) begin
      if (inc_vec[i] && !dec_vec[i]) begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end else if (dec_vec[i] && !inc_vec[i]) begin
        cnt_d[i] = cnt_q[i] - CW'(1);
      end
    end
  end

  // State registers; reset drops every in-flight tag so no stale result is returned.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q     <= '0;
      cnt_q        <= '0;
      tag_vld_q    <= '0;
      tag_id_q     <= '0;
      tree_a_q     <= 16'h0000;
      resp_valid_q <= '0;
      resp_b_q     <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      cnt_q        <= cnt_d;
      tag_vld_q    <= tag_vld_d;
      tag_id_q     <= tag_id_d;
      tree_a_q     <= tree_a_d;
      resp_valid_q <= resp_valid_d;
      resp_b_q     <= resp_b_d;
    end
  end

  assign tree_a     = tree_a_q;
  assign resp_valid = resp_valid_q;
  assign resp_b     = resp_b_q;
  assign busy       = |tag_vld_q;

endmodule
